// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage in front of a word-organised data memory that has no
// byte enables. Byte/half/word loads and stores arrive from execute over a
// valid/ready handshake. Byte addresses become word indices, and sub-word
// stores use read-modify-write. Load data is sign- or zero-extended and
// returned to writeback over a second valid/ready handshake. Every mem_* and
// resp_* output is a flop, so the memory sees stable address/data all cycle.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready is high only in IDLE)
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    loads: 1 = zero-extend, 0 = sign-extend
//   req_addr        byte address
//   req_wdata       store data, right-justified
//   resp_valid/ready response handshake
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_error      misaligned, illegal size or out-of-range request
//   mem_address     word index {2'b00, addr[31:2]}
//   mem_write_data  full word to write
//   mem_read        memory read enable
//   mem_write       memory write enable (one cycle per store)
//   mem_read_data   combinational read data from memory
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module load_store_unit #(
  parameter int MEM_WORDS  = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;   // only the low half is ever merged into memory
  logic        req_err;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  uns
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = uns ? {{(DATA_WIDTH-8){1'b0}}, b}
                         : {{(DATA_WIDTH-8){b[7]}}, b};
      SZ_HALF: res = uns ? {{(DATA_WIDTH-16){1'b0}}, h}
                         : {{(DATA_WIDTH-16){h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store byte/half onto the word read back from memory.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wdata,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = word;
    if (size == SZ_BYTE) merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else                 merged[{lane[1], 4'b0000} +: 16] = wdata;
    return merged;
  endfunction

  assign req_err = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || (req_addr[31:2] >= WORD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      write_q        <= 1'b0;
      size_q         <= SZ_BYTE;
      unsigned_q     <= 1'b0;
      lane_q         <= 2'b00;
      wdata_q        <= '0;
    end else begin
      case (state_q)
        // Accept: capture the request and launch the first memory cycle.
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q     <= req_write;
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            req_ready   <= 1'b0;
            mem_address <= {2'b00, req_addr[31:2]};
            if (req_err) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              // Full-word stores need no read-back.
              state_q        <= WRITE;
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state_q  <= READ;
              mem_read <= 1'b1;
            end
          end
        end
        // Read: memory data is valid by the end of this cycle.
        READ: begin
          mem_read <= 1'b0;
          if (write_q) begin
            state_q        <= WRITE;
            mem_write      <= 1'b1;
            mem_write_data <= store_merge(mem_read_data, wdata_q, size_q, lane_q);
          end else begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_extract(mem_read_data, size_q, lane_q, unsigned_q);
          end
        end
        // Write: single write strobe, then report completion.
        WRITE: begin
          mem_write  <= 1'b0;
          state_q    <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        // Respond: hold until writeback takes it.
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Word memory model: combinational read, synchronous write.
  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[7:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
  endtask

  // Take the pending response and confirm the unit goes idle.
  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, sz, u, a, 32'h0);
    tick();
    req_valid = 1'b0;
    chk({tag, "_c1_read"}, 32'(mem_read), 32'd1);
    chk({tag, "_c1_addr"}, mem_address, {2'b00, a[31:2]});
    chk({tag, "_c1_valid"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_c2_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_c2_rdata"}, resp_rdata, exp);
    chk({tag, "_c2_err"}, 32'(resp_error), 32'd0);
    handshake(tag);
  endtask

  task automatic store_sub(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] merged);
    int w0;
    w0 = wr_cnt;
    drive(1'b1, sz, 1'b0, a, d);
    tick();
    req_valid = 1'b0;
    chk({tag, "_c1_read"}, 32'(mem_read), 32'd1);
    chk({tag, "_c1_write"}, 32'(mem_write), 32'd0);
    tick();
    chk({tag, "_c2_write"}, 32'(mem_write), 32'd1);
    chk({tag, "_c2_addr"}, mem_address, {2'b00, a[31:2]});
    chk({tag, "_c2_wdata"}, mem_write_data, merged);
    chk({tag, "_c2_valid"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_c3_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_c3_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_c3_err"}, 32'(resp_error), 32'd0);
    chk({tag, "_c3_write"}, 32'(mem_write), 32'd0);
    handshake(tag);
    chk({tag, "_one_write"}, 32'(wr_cnt - w0), 32'd1);
  endtask

  task automatic error_check(input string tag, input logic w, input logic [1:0] sz,
                             input logic [31:0] a);
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    drive(w, sz, 1'b0, a, 32'hFFFF_FFFF);
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_error), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    handshake(tag);
    chk({tag, "_err_clr"}, 32'(resp_error), 32'd0);
    chk({tag, "_no_read"}, 32'(rd_cnt - r0), 32'd0);
    chk({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2]   = 32'hDEAD_BEEF;
    mem[3]   = 32'hAABB_CCDD;
    mem[5]   = 32'h80FF_7F01;
    mem[255] = 32'h5A00_0000;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;

    // Reset values
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    #4 rst = 1'b0;
    tick();

    // Reset asserted in the middle of a load's READ cycle
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("midrst_read_before", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_mem_addr", mem_address, 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    tick();
    chk("midrst_no_resp2", 32'(resp_valid), 32'd0);
    load_check("postrst_word", 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);

    // Byte and half loads from word 5 = 0x80FF7F01 (little-endian lanes)
    load_check("lb_s_17", 2'b00, 1'b0, 32'h17, 32'hFFFF_FF80);
    load_check("lb_u_17", 2'b00, 1'b1, 32'h17, 32'h0000_0080);
    load_check("lb_s_16", 2'b00, 1'b0, 32'h16, 32'hFFFF_FFFF);
    load_check("lb_u_16", 2'b00, 1'b1, 32'h16, 32'h0000_00FF);
    load_check("lb_s_15", 2'b00, 1'b0, 32'h15, 32'h0000_007F);
    load_check("lh_s_14", 2'b01, 1'b0, 32'h14, 32'h0000_7F01);
    load_check("lh_s_16", 2'b01, 1'b0, 32'h16, 32'hFFFF_80FF);
    load_check("lh_u_16", 2'b01, 1'b1, 32'h16, 32'h0000_80FF);
    load_check("lw_u_14", 2'b10, 1'b1, 32'h14, 32'h80FF_7F01);
    load_check("lb_top_3ff", 2'b00, 1'b0, 32'h3FF, 32'h0000_005A);

    // Halfword store merge into word 3 = 0xAABBCCDD
    store_sub("sh_0e", 2'b01, 32'h0E, 32'h1234_1234, 32'h1234_CCDD);
    chk("sh_0e_mem", mem[3], 32'h1234_CCDD);

    // Error requests
    error_check("err_lw_21", 1'b0, 2'b10, 32'h21);
    error_check("err_lh_400", 1'b0, 2'b01, 32'h400);
    error_check("err_lh_odd", 1'b0, 2'b01, 32'h15);
    error_check("err_size3", 1'b0, 2'b11, 32'h10);
    error_check("err_sw_mis", 1'b1, 2'b10, 32'h42);
    error_check("err_sb_oor", 1'b1, 2'b00, 32'h400);

    // Backpressure with a second request waiting
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    tick();
    drive(1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
    chk("bp_c1_ready", 32'(req_ready), 32'd0);
    tick();
    chk("bp_c2_valid", 32'(resp_valid), 32'd1);
    chk("bp_c2_rdata", resp_rdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_read", 32'(mem_read), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_hs_valid", 32'(resp_valid), 32'd0);
    chk("bp_hs_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_acc", 32'(req_ready), 32'd0);
    chk("bp_second_read", 32'(mem_read), 32'd1);
    chk("bp_second_addr", mem_address, 32'd5);
    tick();
    chk("bp_second_valid", 32'(resp_valid), 32'd1);
    chk("bp_second_rdata", resp_rdata, 32'h0000_007F);
    handshake("bp_second");

    // Back-to-back byte stores to word 16, then word load
    store_sub("sb_40", 2'b00, 32'h40, 32'hA5A5_A511, 32'h0000_0011);
    store_sub("sb_41", 2'b00, 32'h41, 32'hFFFF_FF22, 32'h0000_2211);
    store_sub("sb_42", 2'b00, 32'h42, 32'h0000_0033, 32'h0033_2211);
    store_sub("sb_43", 2'b00, 32'h43, 32'h1234_5644, 32'h4433_2211);
    load_check("lw_40", 2'b10, 1'b0, 32'h40, 32'h4433_2211);

    // Word store: no read, write in the first cycle
    begin
      int r0;
      r0 = rd_cnt;
      drive(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D);
      tick();
      req_valid = 1'b0;
      chk("sw_c1_write", 32'(mem_write), 32'd1);
      chk("sw_c1_read", 32'(mem_read), 32'd0);
      chk("sw_c1_addr", mem_address, 32'd17);
      chk("sw_c1_wdata", mem_write_data, 32'hCAFE_F00D);
      chk("sw_c1_valid", 32'(resp_valid), 32'd0);
      tick();
      chk("sw_c2_valid", 32'(resp_valid), 32'd1);
      chk("sw_c2_write", 32'(mem_write), 32'd0);
      chk("sw_c2_rdata", resp_rdata, 32'h0);
      handshake("sw");
      chk("sw_no_read", 32'(rd_cnt - r0), 32'd0);
    end
    load_check("lh_u_46", 2'b01, 1'b1, 32'h46, 32'h0000_CAFE);
    load_check("lh_s_46", 2'b01, 1'b0, 32'h46, 32'hFFFF_CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
